reset_sequencer: RTL and testbench
==================================

Name: reset_sequencer

Overview:
- Parametrised successor to the fixed single-line Dreamcast reset pulse generator (one 32-bit counter, hard-wired 8_000_000-cycle hold).
- Drives CHANNELS open-drain-style active-low reset lines. Holds them asserted while any monitored PLL lock is missing. Applies a programmable-length reset pulse on request, then releases channels one by one at a fixed stagger.
- Sits in the control_clock domain. All inputs arrive already synchronised; outputs feed tristate pads and downstream resets.

Parameters:
- CHANNELS, 3, number of reset outputs (1..8)
- LOCK_INPUTS, 2, number of lock inputs monitored (1..8)
- COUNTER_WIDTH, 32, width of pulse counter and pulse_len
- DEFAULT_PULSE, 8_000_000, pulse length used after lock recovery and when pulse_len==0
- STAGE_GAP, 255, cycles between successive channel releases (>=1)
- DEBOUNCE, 16, consecutive all-locked cycles required to leave HOLD (>=1)

Ports:
- clock  in  1  control clock
- reset  in  1  synchronous, active-high
- locked  in  LOCK_INPUTS  PLL lock flags, pre-synchronised
- trigger  in  1  single-cycle reset request (e.g. from the reset_dc flag crossing)
- pulse_len  in  COUNTER_WIDTH  pulse length, sampled on the trigger cycle
- nreset_out  out  CHANNELS  per-channel reset, 0 = asserted
- busy  out  1  high in any state except IDLE
- lockloss_count  out  8  saturating lock-loss event count (only when feature enabled)

Behaviour:
- Single clock. Reset is synchronous and active-high. All outputs are registered.
- While reset=1, and on the first cycle after reset:
  - state=HOLD, nreset_out=0, busy=1, stable counter=0, lockloss_count=0.
- all_locked = &locked.
- HOLD:
  - nreset_out=0, busy=1.
  - Stable counter increments while all_locked and clears when it drops.
  - When all_locked and stable==DEBOUNCE-1: go to ASSERT with count=DEFAULT_PULSE.
  - trigger is ignored.
- ASSERT:
  - nreset_out=0.
  - count decrements each cycle.
  - At count==1: go to RELEASE, idx=0, gap=0.
  - ASSERT lasts exactly the loaded length in cycles.
- RELEASE:
  - On the entry cycle nreset_out[0] goes to 1.
  - Every STAGE_GAP cycles, idx increments and nreset_out[idx] goes to 1.
  - nreset_out[k] rises exactly L + k*STAGE_GAP cycles after ASSERT entry, where L is the loaded length.
  - Released channels stay 1.
  - After channel CHANNELS-1 is released, go to IDLE on the next cycle.
- IDLE:
  - nreset_out all 1, busy=0.
  - trigger loads count = (pulse_len==0 ? DEFAULT_PULSE : pulse_len) and goes to ASSERT.
- Retrigger: trigger in ASSERT or RELEASE restarts ASSERT with the new length; all channels return to 0 on the next cycle.
- Lock loss: all_locked==0 in ASSERT, RELEASE or IDLE goes to HOLD next cycle, with stable counter cleared.
- Simultaneous trigger and lock loss: lock loss wins.
- Counter arithmetic is COUNTER_WIDTH unsigned with no wrap; count is never decremented below 1.

Optional Feature:
- Macro: RESET_SEQ_LOCKLOSS_COUNT_EN.
- Defined:
  - Each transition into HOLD from ASSERT, RELEASE or IDLE increments lockloss_count by 1.
  - The count saturates at 255.
  - Cleared only by reset.
- Undefined:
  - lockloss_count is tied to 0 and no counter logic is generated.

Test Plan:
(All with CHANNELS=3, LOCK_INPUTS=2, DEFAULT_PULSE=10, STAGE_GAP=4, DEBOUNCE=3.)
- Reset release, locked=2'b11 from cycle 0:
  - HOLD for 3 cycles, then ASSERT.
  - nreset_out bits 0/1/2 rise at 10/14/18 cycles after ASSERT entry.
  - busy falls the cycle after bit 2 rises.
- Debounce glitch: locked=11 for 2 cycles, 01 for 1, then 11 -> ASSERT entered only after 3 further consecutive locked cycles.
- IDLE, trigger with pulse_len=5 -> nreset_out=000 for 5 cycles; bits rise at 5/9/13. With pulse_len=0 the same sequence uses 10/14/18.
- Trigger 2 cycles after bit 0 rises (in RELEASE), pulse_len=6 -> all bits return to 0 the next cycle; re-release at 6/10/14 from the retrigger.
- locked drops to 10 during RELEASE with a trigger in the same cycle:
  - HOLD next cycle, nreset_out=000, trigger discarded.
  - Recovery follows the DEBOUNCE+DEFAULT_PULSE sequence.
  - With RESET_SEQ_LOCKLOSS_COUNT_EN, lockloss_count=1.
- 300 lock-loss events with the feature enabled -> lockloss_count saturates at 255. With the feature disabled -> constant 0.

Source files
------------

// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//
// Purpose:
//   Generates CHANNELS active-low reset lines in the control clock domain.
//   The lines are held asserted while any monitored PLL lock is missing.
//   After DEBOUNCE consecutive all-locked cycles, or on a trigger request, a
//   reset pulse of programmable length is applied. The channels are then
//   released one at a time, STAGE_GAP cycles apart.
//
// Ports:
//   clock          in   control clock
//   reset          in   synchronous, active-high reset
//   locked         in   [LOCK_INPUTS]    PLL lock flags, already synchronised
//   trigger        in   single-cycle reset request
//   pulse_len      in   [COUNTER_WIDTH]  pulse length, sampled with trigger
//                                        (0 selects DEFAULT_PULSE)
//   nreset_out     out  [CHANNELS]       per-channel reset, 0 = asserted
//   busy           out  high in every state except IDLE
//   lockloss_count out  [8]              saturating count of lock-loss events
//
// Optional feature:
//   RESET_SEQ_LOCKLOSS_COUNT_EN - when defined, every entry into HOLD from
//   ASSERT, RELEASE or IDLE increments lockloss_count, which saturates at 255.
//   When undefined, lockloss_count is tied to zero.
// -----------------------------------------------------------------------------
module reset_sequencer #(
    parameter int CHANNELS      = 3,
    parameter int LOCK_INPUTS   = 2,
    parameter int COUNTER_WIDTH = 32,
    parameter int DEFAULT_PULSE = 8_000_000,
    parameter int STAGE_GAP     = 255,
    parameter int DEBOUNCE      = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [LOCK_INPUTS-1:0]   locked,
    input  logic                     trigger,
    input  logic [COUNTER_WIDTH-1:0] pulse_len,
    output logic [CHANNELS-1:0]      nreset_out,
    output logic                     busy,
    output logic [7:0]               lockloss_count
);

    localparam int STABLE_W = $clog2(DEBOUNCE + 1);
    localparam int GAP_W    = $clog2(STAGE_GAP + 1);

    localparam logic [COUNTER_WIDTH-1:0] DEFAULT_LEN = COUNTER_WIDTH'(DEFAULT_PULSE);
    localparam logic [COUNTER_WIDTH-1:0] COUNT_ONE   = COUNTER_WIDTH'(1);
    localparam logic [STABLE_W-1:0]      STABLE_LAST = STABLE_W'(DEBOUNCE - 1);
    localparam logic [GAP_W-1:0]         GAP_LAST    = GAP_W'(STAGE_GAP - 1);

    typedef enum logic [1:0] {
        S_HOLD,
        S_ASSERT,
        S_RELEASE,
        S_IDLE
    } state_t;

    state_t                   state_q,  state_d;
    logic [STABLE_W-1:0]      stable_q, stable_d;
    logic [COUNTER_WIDTH-1:0] count_q,  count_d;
    logic [GAP_W-1:0]         gap_q,    gap_d;
    logic [CHANNELS-1:0]      nreset_q, nreset_d;
    logic                     busy_q,   busy_d;

    logic                     all_locked;
    logic [COUNTER_WIDTH-1:0] trigger_len;

    assign all_locked  = &locked;
    assign trigger_len = (pulse_len == '0) ? DEFAULT_LEN : pulse_len;

    always_comb begin
        // NOTE: every next-state signal starts from its current value so that
        // no path through the case statement leaves it unassigned (no latches).
        state_d  = state_q;
        stable_d = stable_q;
        count_d  = count_q;
        gap_d    = gap_q;
        nreset_d = nreset_q;

        case (state_q)
            S_HOLD: begin
                nreset_d = '0;
                if (!all_locked) begin
                    stable_d = '0;
                end else if (stable_q == STABLE_LAST) begin
                    state_d  = S_ASSERT;
                    count_d  = DEFAULT_LEN;
                    stable_d = '0;
                end else begin
                    stable_d = stable_q + STABLE_W'(1);
                end
            end

            default: begin
                // Lock loss outranks a simultaneous trigger.
                if (!all_locked) begin
                    state_d  = S_HOLD;
                    stable_d = '0;
                    nreset_d = '0;
                end else if (trigger) begin
                    state_d  = S_ASSERT;
                    count_d  = trigger_len;
                    nreset_d = '0;
                end else begin
                    case (state_q)
                        S_ASSERT: begin
                            // count holds the cycles left including this one,
                            // so ASSERT lasts exactly the loaded length.
                            if (count_q <= COUNT_ONE) begin
                                state_d  = S_RELEASE;
                                gap_d    = '0;
                                nreset_d = CHANNELS'(1);
                            end else begin
                                count_d = count_q - COUNT_ONE;
                            end
                        end
                        S_RELEASE: begin
                            // nreset is a thermometer code: the top bit set
                            // means every channel has been released.
                            if (nreset_q[CHANNELS-1]) begin
                                state_d = S_IDLE;
                            end else if (gap_q == GAP_LAST) begin
                                gap_d    = '0;
                                nreset_d = (nreset_q << 1) | CHANNELS'(1);
                            end else begin
                                gap_d = gap_q + GAP_W'(1);
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (reset) begin
            state_q  <= S_HOLD;
            stable_q <= '0;
            count_q  <= '0;
            gap_q    <= '0;
            nreset_q <= '0;
            busy_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            stable_q <= stable_d;
            count_q  <= count_d;
            gap_q    <= gap_d;
            nreset_q <= nreset_d;
            busy_q   <= busy_d;
        end
    end

    assign nreset_out = nreset_q;
    assign busy       = busy_q;

`ifdef RESET_SEQ_LOCKLOSS_COUNT_EN
    logic [7:0] lockloss_q, lockloss_d;

    always_comb begin
        lockloss_d = lockloss_q;
        if ((state_q != S_HOLD) && !all_locked && (lockloss_q != 8'hFF)) begin
            lockloss_d = lockloss_q + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lockloss_q <= 8'd0;
        end else begin
            lockloss_q <= lockloss_d;
        end
    end

    assign lockloss_count = lockloss_q;
`else
    assign lockloss_count = 8'd0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
//
// Self-checking bench for reset_sequencer with CHANNELS=3, LOCK_INPUTS=2,
// DEFAULT_PULSE=10, STAGE_GAP=4, DEBOUNCE=3. The reference model tracks only
// the mode (hold / sequence / idle), the debounce run length and the number of
// cycles since the pulse started; the expected channel levels are derived from
// "channel k is released once L + k*STAGE_GAP cycles have elapsed".
// Honours RESET_SEQ_LOCKLOSS_COUNT_EN for the lock-loss counter expectation.
// -----------------------------------------------------------------------------
module tb_reset_sequencer;

    localparam int CH  = 3;
    localparam int LI  = 2;
    localparam int CW  = 32;
    localparam int DEF = 10;
    localparam int GAP = 4;
    localparam int DEB = 3;

`ifdef RESET_SEQ_LOCKLOSS_COUNT_EN
    localparam bit LLC_EN = 1'b1;
`else
    localparam bit LLC_EN = 1'b0;
`endif

    localparam int M_HOLD = 0;
    localparam int M_SEQ  = 1;
    localparam int M_IDLE = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic [LI-1:0] locked;
    logic          trigger;
    logic [CW-1:0] pulse_len;
    logic [CH-1:0] nreset_out;
    logic          busy;
    logic [7:0]    lockloss_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    bit     m_valid = 1'b0;
    int     m_mode;
    int     m_stable;
    longint m_t;
    longint m_len;
    int     m_llc;

    always #5 clock = ~clock;

    reset_sequencer #(
        .CHANNELS      (CH),
        .LOCK_INPUTS   (LI),
        .COUNTER_WIDTH (CW),
        .DEFAULT_PULSE (DEF),
        .STAGE_GAP     (GAP),
        .DEBOUNCE      (DEB)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .locked         (locked),
        .trigger        (trigger),
        .pulse_len      (pulse_len),
        .nreset_out     (nreset_out),
        .busy           (busy),
        .lockloss_count (lockloss_count)
    );

    task automatic check(input string name, input longint actual, input longint expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    // Advance the model by one clock edge using the inputs the DUT sees.
    task automatic model_step();
        if (reset) begin
            m_valid  = 1'b1;
            m_mode   = M_HOLD;
            m_stable = 0;
            m_t      = 0;
            m_len    = 0;
            m_llc    = 0;
        end else if (m_valid) begin
            if (m_mode == M_HOLD) begin
                if (&locked) begin
                    if (m_stable == DEB - 1) begin
                        m_mode   = M_SEQ;
                        m_t      = 0;
                        m_len    = DEF;
                        m_stable = 0;
                    end else begin
                        m_stable++;
                    end
                end else begin
                    m_stable = 0;
                end
            end else if (!(&locked)) begin
                m_mode   = M_HOLD;
                m_stable = 0;
                if (m_llc < 255) m_llc++;
            end else if (trigger) begin
                m_mode = M_SEQ;
                m_t    = 0;
                m_len  = (pulse_len == 0) ? DEF : longint'(pulse_len);
            end else if (m_mode == M_SEQ) begin
                m_t++;
                if (m_t > m_len + (CH - 1) * GAP) m_mode = M_IDLE;
            end
        end
    endtask

    function automatic logic [CH-1:0] exp_nreset();
        logic [CH-1:0] v;
        for (int k = 0; k < CH; k++) begin
            if (m_mode == M_IDLE)     v[k] = 1'b1;
            else if (m_mode == M_SEQ) v[k] = (m_t >= m_len + longint'(k * GAP));
            else                      v[k] = 1'b0;
        end
        return v;
    endfunction

    // Single compare process: outputs against the model, every cycle.
    always @(negedge clock) begin
        if (m_valid) begin
            check("model_nreset_out", longint'(nreset_out), longint'(exp_nreset()));
            check("model_busy", longint'(busy), longint'(m_mode != M_IDLE));
            check("model_lockloss_count", longint'(lockloss_count), LLC_EN ? longint'(m_llc) : 0);
        end
    end

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        trigger = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic pulse_trigger(input int len);
        pulse_len = CW'(len);
        trigger   = 1'b1;
        tick();
        trigger = 1'b0;
    endtask

    // Literal release timeline: cycle 0 is the current cycle; bits rise at
    // r0/r1/r2 and busy falls one cycle after r2.
    task automatic check_rises(input string name, input int r0, input int r1, input int r2);
        for (int c = 0; c <= r2 + 1; c++) begin
            if (c > 0) tick();
            if (c == 0 || c == r0 - 1) check({name, "_all_low"}, longint'(nreset_out), 0);
            if (c == r0)     check({name, "_bit0_up"}, longint'(nreset_out), 1);
            if (c == r1 - 1) check({name, "_bit1_wait"}, longint'(nreset_out), 1);
            if (c == r1)     check({name, "_bit1_up"}, longint'(nreset_out), 3);
            if (c == r2 - 1) check({name, "_bit2_wait"}, longint'(nreset_out), 3);
            if (c == r2) begin
                check({name, "_bit2_up"}, longint'(nreset_out), 7);
                check({name, "_busy_hi"}, longint'(busy), 1);
            end
            if (c == r2 + 1) check({name, "_busy_lo"}, longint'(busy), 0);
        end
    endtask

    initial begin
        reset     = 1'b1;
        locked    = 2'b11;
        trigger   = 1'b0;
        pulse_len = '0;

        // Power-on: HOLD for 3 cycles, then 10-cycle pulse, stagger 4.
        do_reset();
        check("reset_nreset_out", longint'(nreset_out), 0);
        check("reset_busy", longint'(busy), 1);
        check("reset_lockloss", longint'(lockloss_count), 0);
        check_rises("power_on", 13, 17, 21);

        // Debounce glitch restarts the all-locked run.
        do_reset();
        tick();
        tick();
        locked = 2'b01;
        tick();
        locked = 2'b11;
        check_rises("debounce", 13, 17, 21);

        // Triggers from IDLE: explicit length, then zero selects the default.
        pulse_trigger(5);
        check_rises("trig_len5", 5, 9, 13);
        pulse_trigger(0);
        check_rises("trig_len0", 10, 14, 18);

        // Retrigger two cycles after bit 0 rises.
        pulse_trigger(0);
        for (int i = 0; i < 12; i++) tick();
        check("retrig_pre_bit0", longint'(nreset_out), 1);
        pulse_trigger(6);
        check_rises("retrigger", 6, 10, 14);

        // Lock loss with a simultaneous trigger during RELEASE.
        do_reset();
        for (int i = 0; i < 14; i++) tick();
        check("lockloss_pre_bit0", longint'(nreset_out), 1);
        locked    = 2'b10;
        pulse_len = CW'(3);
        trigger   = 1'b1;
        tick();
        locked  = 2'b11;
        trigger = 1'b0;
        check("lockloss_hold_nreset", longint'(nreset_out), 0);
        check("lockloss_hold_busy", longint'(busy), 1);
        check("lockloss_count_one", longint'(lockloss_count), LLC_EN ? 1 : 0);
        check_rises("recovery", 13, 17, 21);

        // 300 further lock-loss events: saturation (or constant zero).
        for (int i = 0; i < 300; i++) begin
            locked = 2'b11;
            tick();
            tick();
            tick();
            locked = 2'b01;
            tick();
        end
        locked = 2'b11;
        check("lockloss_saturated", longint'(lockloss_count), LLC_EN ? 255 : 0);

        // Randomised traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            reset     = ($urandom_range(0, 999) == 0);
            locked    = ($urandom_range(0, 59) == 0) ? LI'($urandom_range(0, 3)) : 2'b11;
            trigger   = ($urandom_range(0, 29) == 0);
            pulse_len = CW'($urandom_range(0, 12));
            tick();
        end
        reset   = 1'b0;
        trigger = 1'b0;
        locked  = 2'b11;
        for (int i = 0; i < 40; i++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
